// File: rtl/frac_cen_gen_pkg.sv
// Shared helpers for the fractional clock-enable generator.
//   low_ones(v, k): 1 when the k least-significant bits of v are all ones
//                   (trivially 1 for k = 0). It builds the binary
//                   sub-multiple masks from the edge counter.
package frac_cen_gen_pkg;

  function automatic logic low_ones(input logic [31:0] v, input int unsigned k);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k && !v[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/frac_cen_gen.sv
// Fractional clock-enable generator.
// Emits one-clock enable pulses at an average rate of clk*n/m using an
// integer accumulator (no drift). Output k runs at that rate / 2^k, and cenb
// pulses fall roughly half a period after the matching cen.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset (clears all state and outputs)
//   n     in   WC-bit numerator, added to the accumulator every clk
//   m     in   WC-bit denominator, the wrap limit (n <= m expected)
//   cen   out  W enable pulses; cen[k] at clk*n/(m*2^k)
//   cenb  out  W mid-period enable pulses, same rates as cen
module frac_cen_gen
  import frac_cen_gen_pkg::*;
#(
  parameter int W  = 2,
  parameter int WC = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WC-1:0] n,
  input  logic [WC-1:0] m,
  output logic [W-1:0]  cen,
  output logic [W-1:0]  cenb
);

  logic [WC:0]   acc;
  logic          half;
  logic [W-1:0]  edgecnt;

  logic [WC:0]   n_ext;
  logic [WC:0]   m_ext;
  logic [WC:0]   nxt;
  logic [WC:0]   absmax;
  logic [WC:0]   half_thr;
  logic [31:0]   edge_ext;
  logic [W-1:0]  sub_mask;

  // All sums are kept in WC+1 bits, one bit wider than the ratio inputs.
  assign n_ext    = {1'b0, n};
  assign m_ext    = {1'b0, m};
  assign nxt      = acc + n_ext;
  assign absmax   = m_ext + n_ext;
  assign half_thr = m_ext >> 1;
  assign edge_ext = 32'(edgecnt);

  // Output k fires only on every 2^k-th period: the low k bits of the
  // pre-increment edge counter must all be ones. Bit 0 always fires.
  for (genvar k = 0; k < W; k++) begin : g_mask
    assign sub_mask[k] = low_ones(edge_ext, k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      half    <= 1'b0;
      edgecnt <= '0;
      cen     <= '0;
      cenb    <= '0;
    end else begin
      cen  <= '0;
      cenb <= '0;
      if (acc >= absmax) begin
        // Accumulator outside any reachable range (ratio changed on the
        // fly): restart the period quietly.
        acc  <= '0;
        half <= 1'b0;
      end else if (nxt >= m_ext) begin
        acc     <= nxt - m_ext;
        half    <= 1'b0;
        edgecnt <= edgecnt + W'(1);
        cen     <= sub_mask;
      end else begin
        acc <= nxt;
        // half blocks a second mid-period pulse within the same period.
        if (nxt >= half_thr && !half) begin
          half <= 1'b1;
          cenb <= sub_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_cen_gen.sv
// Testbench for frac_cen_gen (W=2, WC=10).
module tb_frac_cen_gen;

  logic       clk;
  logic       rst;
  logic [9:0] n;
  logic [9:0] m;
  logic [1:0] cen;
  logic [1:0] cenb;

  frac_cen_gen #(.W(2), .WC(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .n    (n),
    .m    (m),
    .cen  (cen),
    .cenb (cenb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] c;
    logic [1:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc;
  bit  sb_on    = 1'b0;
  int  cnt_c0, cnt_c1, cnt_b0, cnt_b1;

  // Number of rising edges since reset release; edge 1 is the first one.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: every non-zero output is matched against the next expected
  // event in scoreboard mode, or tallied in counting mode.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_on) begin
        if ((cen | cenb) != 2'b00) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse edge=%0d cen=%b cenb=%b required no pulse", cyc, cen, cenb);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.c != cen || e.b != cenb) begin
              failures++;
              $display("FAIL pulse_event got edge=%0d cen=%b cenb=%b required edge=%0d cen=%b cenb=%b",
                       cyc, cen, cenb, e.cyc, e.c, e.b);
            end
          end
        end
      end else begin
        if (cen[0])  cnt_c0++;
        if (cen[1])  cnt_c1++;
        if (cenb[0]) cnt_b0++;
        if (cenb[1]) cnt_b1++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int cy, input logic [1:0] c, input logic [1:0] b);
    ev_t e;
    e.cyc = cy;
    e.c   = c;
    e.b   = b;
    exp_q.push_back(e);
  endtask

  // Holds reset with the new ratio applied, checks the reset outputs, then
  // releases reset on a falling edge.
  task automatic do_reset(input string name, input int nn, input int mm, input bit sb);
    @(negedge clk);
    rst   = 1'b1;
    n     = 10'(nn);
    m     = 10'(mm);
    sb_on = sb;
    exp_q.delete();
    cnt_c0 = 0; cnt_c1 = 0; cnt_b0 = 0; cnt_b1 = 0;
    repeat (2) @(negedge clk);
    chk({name, "_reset_cen"},  int'(cen),  0);
    chk({name, "_reset_cenb"}, int'(cenb), 0);
    rst = 1'b0;
  endtask

  task automatic run_edges(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    n   = 10'd1;
    m   = 10'd4;

    // n=1, m=4: cenb at 2 mod 4, cen at 0 mod 4; sub-multiples every
    // second period (edge counter low bit set before the increment).
    do_reset("n1m4", 1, 4, 1'b1);
    push(2,  2'b00, 2'b01); push(4,  2'b01, 2'b00);
    push(6,  2'b00, 2'b11); push(8,  2'b11, 2'b00);
    push(10, 2'b00, 2'b01); push(12, 2'b01, 2'b00);
    push(14, 2'b00, 2'b11); push(16, 2'b11, 2'b00);
    push(18, 2'b00, 2'b01); push(20, 2'b01, 2'b00);
    push(22, 2'b00, 2'b11); push(24, 2'b11, 2'b00);
    run_edges(25);
    chk("n1m4_pending", exp_q.size(), 0);

    // n=105, m=704 over 1408 clocks: exact pulse counts.
    do_reset("fm", 105, 704, 1'b0);
    run_edges(1408);
    chk("fm_cen0",  cnt_c0, 210);
    chk("fm_cen1",  cnt_c1, 105);
    chk("fm_cenb0", cnt_b0, 210);
    chk("fm_cenb1", cnt_b1, 105);

    // n=0: nothing ever fires.
    do_reset("n0", 0, 704, 1'b0);
    run_edges(2000);
    chk("n0_cen0",  cnt_c0, 0);
    chk("n0_cen1",  cnt_c1, 0);
    chk("n0_cenb0", cnt_b0, 0);
    chk("n0_cenb1", cnt_b1, 0);

    // n=m: cen[0] every cycle, cen[1] every other cycle, no cenb.
    do_reset("n4m4", 4, 4, 1'b1);
    push(1, 2'b01, 2'b00); push(2, 2'b11, 2'b00);
    push(3, 2'b01, 2'b00); push(4, 2'b11, 2'b00);
    push(5, 2'b01, 2'b00); push(6, 2'b11, 2'b00);
    push(7, 2'b01, 2'b00); push(8, 2'b11, 2'b00);
    run_edges(8);
    chk("n4m4_pending", exp_q.size(), 0);

    // Asynchronous reset while a pulse is on the output.
    @(posedge clk);
    #1;
    chk("async_pre_cen", int'(cen), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_cen",  int'(cen),  0);
    chk("async_cenb", int'(cenb), 0);

    // Corrupt state: switching m from 700 to 100 while acc=600 clears the
    // accumulator silently at edge 601; regular 100-clock periods follow.
    do_reset("corrupt", 1, 700, 1'b1);
    push(350, 2'b00, 2'b01);
    push(651, 2'b00, 2'b01); push(701, 2'b01, 2'b00);
    push(751, 2'b00, 2'b11); push(801, 2'b11, 2'b00);
    push(851, 2'b00, 2'b01); push(901, 2'b01, 2'b00);
    run_edges(600);
    m = 10'd100;
    run_edges(305);
    chk("corrupt_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
